// File: rtl/phase_seq_if.sv
// phase_seq bus: run/opcode/flag inputs and the phase,
// memory request and retire-count outputs of the sequencer.
interface phase_seq_if;
    logic        run;
    logic [5:0]  op;
    logic        zero;
    logic        neg;
    logic        mem_ready;
    logic [4:0]  phase;
    logic        ct_taken;
    logic        mem_req;
    logic        halted;
    logic [15:0] retired;

    modport master (
        output run, op, zero, neg, mem_ready,
        input  phase, ct_taken, mem_req, halted, retired
    );

    modport slave (
        input  run, op, zero, neg, mem_ready,
        output phase, ct_taken, mem_req, halted, retired
    );
endinterface

// File: rtl/phase_seq.sv
// Instruction phase sequencer: F/R/X/M/W one-hot phases,
// memory wait states, branch resolution and retire counter.
module phase_seq (
    input  logic        clk,
    input  logic        rst_n,
    phase_seq_if.slave  bus
);

    localparam logic [5:0] OP_HLT = 6'b111111;
    localparam logic [5:0] OP_LD  = 6'b010000;
    localparam logic [5:0] OP_ST  = 6'b010001;
    localparam logic [5:0] OP_JMP = 6'b100000;
    localparam logic [5:0] OP_BZ  = 6'b100001;
    localparam logic [5:0] OP_BN  = 6'b100010;

    typedef enum logic [2:0] {
        S_IDLE,
        S_F,
        S_R,
        S_X,
        S_M,
        S_W,
        S_HALT
    } state_t;

    state_t      state;
    state_t      nxt;
    logic        zf_q;
    logic        nf_q;
    logic        ct_q;
    logic        ct_sel;
    logic        is_mem;
    logic [15:0] ret_q;

    assign is_mem = (bus.op == OP_LD) || (bus.op == OP_ST);

    // branch outcome from the opcode and the flags saved in X
    always_comb begin
        ct_sel = 1'b0;
        if (bus.op == OP_JMP)
            ct_sel = 1'b1;
        else if (bus.op == OP_BZ)
            ct_sel = zf_q;
        else if (bus.op == OP_BN)
            ct_sel = nf_q;
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= nxt;
    end

    // next-state logic
    always_comb begin
        nxt = state;
        unique case (state)
            S_IDLE: nxt = bus.run ? S_F : S_IDLE;
            S_F:    nxt = S_R;
            S_R:    nxt = bus.mem_ready ? S_X : S_R;
            S_X:    nxt = (bus.op == OP_HLT) ? S_HALT : S_M;
            S_M: begin
                if (!is_mem || bus.mem_ready)
                    nxt = S_W;
            end
            S_W:    nxt = bus.run ? S_F : S_IDLE;
            S_HALT: nxt = S_HALT;
            default: nxt = S_IDLE;
        endcase
    end

    // Moore outputs decoded from the current state
    always_comb begin
        bus.phase   = 5'b00000;
        bus.mem_req = 1'b0;
        bus.halted  = 1'b0;
        unique case (state)
            S_F:    bus.phase = 5'b00001;
            S_R: begin
                bus.phase   = 5'b00010;
                bus.mem_req = 1'b1;
            end
            S_X:    bus.phase = 5'b00100;
            S_M: begin
                bus.phase   = 5'b01000;
                bus.mem_req = is_mem;
            end
            S_W:    bus.phase = 5'b10000;
            S_HALT: bus.halted = 1'b1;
            default: bus.phase = 5'b00000;
        endcase
    end

    // capture ALU flags as X hands over to M
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zf_q <= 1'b0;
            nf_q <= 1'b0;
        end else if (state == S_X && nxt == S_M) begin
            zf_q <= bus.zero;
            nf_q <= bus.neg;
        end
    end

    // ct_taken is loaded on W entry and cleared on every other edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ct_q <= 1'b0;
        else if (state == S_M && nxt == S_W)
            ct_q <= ct_sel;
        else
            ct_q <= 1'b0;
    end

    // count instructions as they leave W (wraps naturally)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ret_q <= 16'h0000;
        else if (state == S_W)
            ret_q <= ret_q + 16'h0001;
    end

    assign bus.ct_taken = ct_q;
    assign bus.retired  = ret_q;

endmodule

// File: tb/tb_phase_seq.sv
// Randomized bench for phase_seq: instruction plans are expanded
// into expected per-cycle phase/mem_req/ct_taken/retired values.
module tb_phase_seq;

    localparam logic [5:0] OP_NOP = 6'b000001;
    localparam logic [5:0] OP_HLT = 6'b111111;
    localparam logic [5:0] OP_LD  = 6'b010000;
    localparam logic [5:0] OP_ST  = 6'b010001;
    localparam logic [5:0] OP_JMP = 6'b100000;
    localparam logic [5:0] OP_BZ  = 6'b100001;
    localparam logic [5:0] OP_BN  = 6'b100010;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_chk = 0;
    int n_err = 0;
    logic [15:0] exp_ret = 16'h0000;

    phase_seq_if bus ();

    phase_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic check(input string tag, input logic [15:0] got,
                         input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_outs(input logic [4:0] ph, input logic mr,
                            input logic ct, input logic hl);
        check("phase", {11'd0, bus.phase}, {11'd0, ph});
        check("mem_req", {15'd0, bus.mem_req}, {15'd0, mr});
        check("ct_taken", {15'd0, bus.ct_taken}, {15'd0, ct});
        check("halted", {15'd0, bus.halted}, {15'd0, hl});
        check("retired", bus.retired, exp_ret);
    endtask

    // one clock cycle: drive inputs and check outputs at negedge
    task automatic cyc(input logic [4:0] ph, input logic mr,
                       input logic ct, input logic hl,
                       input logic [5:0] o, input logic r,
                       input logic mrdy, input logic z, input logic n);
        @(negedge clk);
        bus.op = o;
        bus.run = r;
        bus.mem_ready = mrdy;
        bus.zero = z;
        bus.neg = n;
        chk_outs(ph, mr, ct, hl);
        @(posedge clk);
    endtask

    // expand one instruction plan into its expected cycles
    task automatic instr(input logic [5:0] o, input int rw, input int mw,
                         input logic run_end, input int gap,
                         input logic z, input logic n);
        logic ct;
        logic mem;
        mem = (o == OP_LD) || (o == OP_ST);
        ct = (o == OP_JMP) || (o == OP_BZ && z) || (o == OP_BN && n);
        cyc(5'h01, 0, 0, 0, o, rb(), rb(), rb(), rb());
        for (int i = 0; i <= rw; i++)
            cyc(5'h02, 1, 0, 0, o, rb(), logic'(i == rw), rb(), rb());
        cyc(5'h04, 0, 0, 0, o, rb(), rb(), z, n);
        if (o == OP_HLT)
            return;
        if (mem) begin
            for (int i = 0; i <= mw; i++)
                cyc(5'h08, 1, 0, 0, o, rb(), logic'(i == mw), rb(), rb());
        end else begin
            cyc(5'h08, 0, 0, 0, o, rb(), rb(), rb(), rb());
        end
        cyc(5'h10, 0, ct, 0, o, run_end, rb(), rb(), rb());
        exp_ret = exp_ret + 16'h0001;
        if (!run_end) begin
            for (int i = 0; i < gap; i++)
                cyc(5'h00, 0, 0, 0, o, 0, rb(), rb(), rb());
            cyc(5'h00, 0, 0, 0, o, 1, rb(), rb(), rb());
        end
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        exp_ret = 16'h0000;
        #1;
        chk_outs(5'h00, 0, 0, 0);
        bus.run = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [5:0] ops [7];
    logic [5:0] o;

    initial begin
        ops = '{OP_NOP, OP_LD, OP_ST, OP_JMP, OP_BZ, OP_BN, 6'b000111};
        bus.run = 1'b0;
        bus.op = 6'd0;
        bus.zero = 1'b0;
        bus.neg = 1'b0;
        bus.mem_ready = 1'b0;

        #12;
        chk_outs(5'h00, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(5'h00, 0, 0, 0, OP_NOP, 0, 1, 0, 0);
        cyc(5'h00, 0, 0, 0, OP_NOP, 0, 0, 0, 0);
        cyc(5'h00, 0, 0, 0, OP_NOP, 1, 0, 0, 0);

        instr(OP_NOP, 0, 0, 1, 0, 0, 0);
        instr(OP_BZ, 1, 0, 1, 0, 1, 0);
        instr(OP_BZ, 0, 0, 1, 0, 0, 1);
        instr(OP_LD, 2, 3, 1, 0, 0, 0);
        instr(OP_ST, 0, 1, 0, 2, 0, 0);
        instr(OP_BN, 0, 0, 1, 0, 0, 1);
        instr(OP_BN, 0, 0, 1, 0, 1, 0);
        instr(OP_JMP, 1, 0, 0, 0, 0, 0);

        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 7) == 0) begin
                o = 6'($urandom_range(0, 63));
                if (o == OP_HLT)
                    o = OP_NOP;
            end else begin
                o = ops[$urandom_range(0, 6)];
            end
            instr(o, $urandom_range(0, 3), $urandom_range(0, 3),
                  rb(), $urandom_range(0, 2), rb(), rb());
        end

        #2;
        force dut.ret_q = 16'hFFFF;
        #1;
        release dut.ret_q;
        exp_ret = 16'hFFFF;
        instr(OP_NOP, 0, 0, 1, 0, 0, 0);
        instr(OP_JMP, 0, 0, 1, 0, 0, 0);

        instr(OP_HLT, 1, 0, 1, 0, 0, 0);
        for (int i = 0; i < 6; i++)
            cyc(5'h00, 0, 0, 1, OP_NOP, rb(), rb(), rb(), rb());

        async_reset();
        cyc(5'h00, 0, 0, 0, OP_NOP, 0, 1, 0, 0);
        cyc(5'h00, 0, 0, 0, OP_NOP, 1, 0, 0, 0);
        instr(OP_LD, 0, 0, 1, 0, 0, 0);
        cyc(5'h01, 0, 0, 0, OP_NOP, 1, 0, 0, 0);
        cyc(5'h02, 1, 0, 0, OP_NOP, 1, 0, 0, 0);
        cyc(5'h02, 1, 0, 0, OP_NOP, 1, 0, 0, 0);

        async_reset();
        cyc(5'h00, 0, 0, 0, OP_NOP, 0, 0, 0, 0);
        cyc(5'h00, 0, 0, 0, OP_NOP, 1, 0, 0, 0);
        instr(OP_BZ, 0, 0, 0, 1, 1, 0);
        cyc(5'h01, 0, 0, 0, OP_NOP, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/phase_seq.md
PHASE_SEQ -- requirements
Module: phase_seq

Interface
REQ-001 clk  input  1  single clock; all state changes on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 run  input  1  1 = execute instructions; sampled in IDLE and W.
REQ-004 op  input  6  opcode from instruction register; valid from first X cycle through W.
REQ-005 zero  input  1  ALU zero flag; valid during X.
REQ-006 neg  input  1  ALU negative flag; valid during X.
REQ-007 mem_ready  input  1  memory response/complete strobe, one cycle.
REQ-008 phase  output  5  one-hot {w,m,x,r,f}; bit0=f, bit1=r, bit2=x, bit3=m, bit4=w.
REQ-009 ct_taken  output  1  control transfer taken; meaningful only while phase[4]=1.
REQ-010 mem_req  output  1  memory request pending.
REQ-011 halted  output  1  1 while in HALT.
REQ-012 retired  output  16  count of completed instructions.

Function
REQ-013 States: IDLE, F, R, X, M, W, HALT; phase = 00001/00010/00100/01000/10000 in F/R/X/M/W, 00000 in IDLE and HALT.
REQ-014 IDLE -> F when run=1, else stay.
REQ-015 F lasts exactly one cycle (PC increments once per F cycle); F -> R unconditionally; mem_ready ignored in F.
REQ-016 R: mem_req=1; stay until mem_ready=1, then -> X next edge (instruction fetch response).
REQ-017 X lasts one cycle; if op=6'b111111 (HLT) -> HALT, else -> M.
REQ-018 X also registers zero and neg into internal flag registers at the X->M edge.
REQ-019 M for op=6'b010000 (LD) or 6'b010001 (ST): mem_req=1, stay until mem_ready=1, then -> W; other opcodes: one cycle, mem_req=0, -> W.
REQ-020 ct_taken registered, set on entry to W: op=6'b100000 -> 1; op=6'b100001 -> saved zero; op=6'b100010 -> saved neg; all others -> 0.
REQ-021 ct_taken = 0 in every state except W.
REQ-022 W lasts one cycle; W -> F if run=1, else -> IDLE; retired increments by 1 on every W exit.
REQ-023 retired wraps 16'hFFFF -> 16'h0000; HLT does not increment retired.
REQ-024 mem_req = 0 in IDLE, F, X, W, HALT, and in M for non-memory opcodes.
REQ-025 run deasserted mid-instruction: current instruction completes through W, then IDLE.
REQ-026 HALT is terminal; exit only via reset; halted=1 only in HALT.
REQ-027 mem_ready in any cycle where mem_req=0 has no effect.
REQ-028 Exactly one phase bit high in F..W; never more than one.

Reset
REQ-029 rst_n=0 immediately forces IDLE, phase=0, ct_taken=0, mem_req=0, halted=0, retired=0, flag registers=0, independent of clk.
REQ-030 Reset asserted mid-instruction (including while waiting in R or M) abandons the instruction without incrementing retired.
REQ-031 After rst_n rises, first F occurs no earlier than the edge after run=1 is sampled in IDLE.

Verification
REQ-032 run=1, op=6'b000001, mem_ready one cycle after R entry -> phase 01,02,04,08,10 (hex), F exactly 1 cycle, retired=1 after W, ct_taken=0.
REQ-033 op=6'b100001, zero=1 in X -> ct_taken=1 during W only; repeat with zero=0 -> ct_taken=0.
REQ-034 op=6'b010000, mem_ready delayed 3 cycles in M -> M held 4 cycles with mem_req=1, then W; mem_ready pulsed in F -> no effect.
REQ-035 op=6'b111111 -> HALT after X, phase=0, halted=1, retired unchanged; run toggling has no effect until rst_n=0.
REQ-036 Preload retired=16'hFFFF via 65535 instructions (or force) -> next W exit gives 16'h0000.
REQ-037 rst_n=0 while waiting in R -> outputs zero asynchronously, IDLE; run=1 after release -> clean F.
